// File: rtl/utype_decode_stage.sv
// U-type decode stage: decodes LUI/AUIPC, buffers results in a two-entry
// skid buffer towards execute, and counts U-type entries handed over.
module utype_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc,
    output logic [31:0] imm_u,
    output logic [5:0]  aluSelect,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        is_utype,
    output logic [31:0] utype_count
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [5:0] SEL_NONE  = 6'b000000;
    localparam logic [5:0] SEL_LUI   = 6'b000001;
    localparam logic [5:0] SEL_AUIPC = 6'b000010;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm_u;
        logic [5:0]  alu_sel;
        logic [4:0]  rd;
        logic        reg_write;
        logic        is_utype;
    } entry_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic [31:0] utype_count_q, utype_count_d;

    entry_t      dec_entry;
    logic        in_fire;
    logic        out_fire;

    // Decode the incoming instruction word into a buffer entry.
    always_comb begin
        dec_entry           = '0;
        dec_entry.pc        = pc_in;
        dec_entry.imm_u     = {instr[31:12], 12'b0};
        dec_entry.rd        = instr[11:7];
        dec_entry.alu_sel   = SEL_NONE;
        dec_entry.is_utype  = 1'b0;
        if (instr[6:0] == OPC_LUI) begin
            dec_entry.alu_sel  = SEL_LUI;
            dec_entry.is_utype = 1'b1;
        end else if (instr[6:0] == OPC_AUIPC) begin
            dec_entry.alu_sel  = SEL_AUIPC;
            dec_entry.is_utype = 1'b1;
        end
        dec_entry.reg_write = dec_entry.is_utype && (instr[11:7] != 5'd0);
    end

    // Buffer state, entry movement, registered ready and the U-type counter.
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        utype_count_d = utype_count_q;
        in_fire       = in_valid && in_ready_q;
        out_fire      = (state_q != EMPTY) && out_ready;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    head_d  = dec_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_d  = dec_entry;
                end else if (in_fire) begin
                    tail_d  = dec_entry;
                    state_d = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (out_fire && head_q.is_utype) begin
            utype_count_d = utype_count_q + 32'd1;
        end

        if (flush) begin
            state_d = EMPTY;
        end

        in_ready_d = (state_d != TWO);
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= EMPTY;
            in_ready_q    <= 1'b1;
            head_q        <= '0;
            tail_q        <= '0;
            utype_count_q <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            utype_count_q <= utype_count_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign pc          = head_q.pc;
    assign imm_u       = head_q.imm_u;
    assign aluSelect   = head_q.alu_sel;
    assign rd          = head_q.rd;
    assign reg_write   = head_q.reg_write;
    assign is_utype    = head_q.is_utype;
    assign utype_count = utype_count_q;

endmodule

// File: tb/tb_utype_decode_stage.sv
// Testbench for utype_decode_stage: scenario tasks plus a scoreboard monitor
// that predicts every entry handed to execute.
module tb_utype_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [31:0] imm_u;
    logic [5:0]  aluSelect;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_utype;
    logic [31:0] utype_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [5:0]  alu;
        logic [4:0]  rd;
        logic        rw;
        logic        ut;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] exp_count = 32'h0;
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    utype_decode_stage dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc_in       (pc_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc          (pc),
        .imm_u       (imm_u),
        .aluSelect   (aluSelect),
        .rd          (rd),
        .reg_write   (reg_write),
        .is_utype    (is_utype),
        .utype_count (utype_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference decode of one instruction into the entry execute should see.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
        exp_t e;
        e.pc  = p;
        e.imm = {ins[31:12], 12'h000};
        e.rd  = ins[11:7];
        case (ins[6:0])
            7'b0110111: e.alu = 6'b000001;
            7'b0010111: e.alu = 6'b000010;
            default:    e.alu = 6'b000000;
        endcase
        e.ut = (ins[6:0] == 7'b0110111) || (ins[6:0] == 7'b0010111);
        e.rw = e.ut && (ins[11:7] != 5'd0);
        return e;
    endfunction

    // Scoreboard: pop and compare on output transfers, push on accepted inputs.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_count = 32'h0;
        end else begin
            if (out_valid && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL sb_unexpected got pc=%h imm=%h required no entry", pc, imm_u);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({pc, imm_u, aluSelect, rd, reg_write, is_utype} !== mon_e)
                        $display("[TB] FAIL sb_entry got pc=%h imm=%h sel=%b rd=%0d rw=%b ut=%b required pc=%h imm=%h sel=%b rd=%0d rw=%b ut=%b",
                                 pc, imm_u, aluSelect, rd, reg_write, is_utype,
                                 mon_e.pc, mon_e.imm, mon_e.alu, mon_e.rd, mon_e.rw, mon_e.ut);
                    else
                        pass_cnt++;
                    if (mon_e.ut) exp_count = exp_count + 32'd1;
                end
            end
            if (flush)
                exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back(model(instr, pc_in));
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        instr = 32'h123452B7; pc_in = 32'h0;
        tick;
        tick;
        total_cnt++;
        if ({out_valid, in_ready, pc, imm_u, aluSelect, rd, reg_write, is_utype, utype_count} !==
            {1'b0, 1'b1, 32'h0, 32'h0, 6'h0, 5'h0, 1'b0, 1'b0, 32'h0})
            $display("[TB] FAIL reset_state got ov=%b ir=%b pc=%h imm=%h sel=%b rd=%0d rw=%b ut=%b cnt=%h required ov=0 ir=1 rest zero",
                     out_valid, in_ready, pc, imm_u, aluSelect, rd, reg_write, is_utype, utype_count);
        else
            pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b0;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_lui;
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h123452B7; pc_in = 32'h100;
        tick;
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, pc, imm_u, aluSelect, rd, reg_write, is_utype} !==
            {1'b1, 32'h100, 32'h12345000, 6'b000001, 5'd5, 1'b1, 1'b1})
            $display("[TB] FAIL lui_decode got ov=%b pc=%h imm=%h sel=%b rd=%0d rw=%b ut=%b required ov=1 pc=100 imm=12345000 sel=000001 rd=5 rw=1 ut=1",
                     out_valid, pc, imm_u, aluSelect, rd, reg_write, is_utype);
        else
            pass_cnt++;
        tick;
        total_cnt++;
        if ({out_valid, utype_count} !== {1'b0, 32'd1})
            $display("[TB] FAIL lui_count got ov=%b cnt=%0d required ov=0 cnt=1", out_valid, utype_count);
        else
            pass_cnt++;
    endtask

    task automatic test_auipc;
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFFFF017; pc_in = 32'h200;
        tick;
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, pc, imm_u, aluSelect, rd, reg_write, is_utype} !==
            {1'b1, 32'h200, 32'hFFFFF000, 6'b000010, 5'd0, 1'b0, 1'b1})
            $display("[TB] FAIL auipc_decode got ov=%b pc=%h imm=%h sel=%b rd=%0d rw=%b ut=%b required ov=1 pc=200 imm=fffff000 sel=000010 rd=0 rw=0 ut=1",
                     out_valid, pc, imm_u, aluSelect, rd, reg_write, is_utype);
        else
            pass_cnt++;
        tick;
        total_cnt++;
        if (utype_count !== 32'd2)
            $display("[TB] FAIL auipc_count got %0d required 2", utype_count);
        else
            pass_cnt++;
    endtask

    task automatic test_addi;
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h00500093; pc_in = 32'h300;
        tick;
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, pc, imm_u, aluSelect, rd, reg_write, is_utype} !==
            {1'b1, 32'h300, 32'h00500000, 6'b000000, 5'd1, 1'b0, 1'b0})
            $display("[TB] FAIL addi_decode got ov=%b pc=%h imm=%h sel=%b rd=%0d rw=%b ut=%b required ov=1 pc=300 imm=00500000 sel=000000 rd=1 rw=0 ut=0",
                     out_valid, pc, imm_u, aluSelect, rd, reg_write, is_utype);
        else
            pass_cnt++;
        tick;
        total_cnt++;
        if (utype_count !== 32'd2)
            $display("[TB] FAIL addi_count got %0d required 2", utype_count);
        else
            pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins[3];
        bit          accepted;
        bit          drained;
        ins[0] = 32'hAAAAA0B7;
        ins[1] = 32'h11111117;
        ins[2] = 32'h0F0F01B7;
        out_ready = 1'b0;
        in_valid = 1'b1; instr = ins[0]; pc_in = 32'h400;
        tick;
        instr = ins[1]; pc_in = 32'h404;
        tick;
        instr = ins[2]; pc_in = 32'h408;
        total_cnt++;
        if ({in_ready, out_valid, pc} !== {1'b0, 1'b1, 32'h400})
            $display("[TB] FAIL b2b_full got ir=%b ov=%b pc=%h required ir=0 ov=1 pc=400", in_ready, out_valid, pc);
        else
            pass_cnt++;
        tick;
        tick;
        total_cnt++;
        if ({in_ready, pc, imm_u, aluSelect, rd} !== {1'b0, 32'h400, 32'hAAAAA000, 6'b000001, 5'd1})
            $display("[TB] FAIL b2b_stall_hold got ir=%b pc=%h imm=%h sel=%b rd=%0d required ir=0 pc=400 imm=aaaaa000 sel=000001 rd=1",
                     in_ready, pc, imm_u, aluSelect, rd);
        else
            pass_cnt++;
        out_ready = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) begin
                tick;
                accepted = 1'b1;
                break;
            end
            tick;
        end
        in_valid = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid) begin
                drained = 1'b1;
                break;
            end
            tick;
        end
        total_cnt++;
        if ({accepted, drained, exp_q.size() == 0} !== 3'b111)
            $display("[TB] FAIL b2b_drain got accepted=%b drained=%b pending=%0d required accepted=1 drained=1 pending=0",
                     accepted, drained, exp_q.size());
        else
            pass_cnt++;
        total_cnt++;
        if (utype_count !== 32'd5)
            $display("[TB] FAIL b2b_count got %0d required 5", utype_count);
        else
            pass_cnt++;
    endtask

    task automatic test_throughput;
        logic [6:0] ops[3];
        int         stalls;
        ops[0] = 7'b0110111;
        ops[1] = 7'b0010111;
        ops[2] = 7'b0010011;
        stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            instr = {20'($urandom), 5'(i + 1), ops[i % 3]};
            pc_in = 32'h600 + 32'(4 * i);
            if (!in_ready) stalls++;
            tick;
        end
        in_valid = 1'b0;
        tick;
        total_cnt++;
        if ({stalls == 0, out_valid, exp_q.size() == 0} !== 3'b101)
            $display("[TB] FAIL throughput got stalls=%0d ov=%b pending=%0d required stalls=0 ov=0 pending=0",
                     stalls, out_valid, exp_q.size());
        else
            pass_cnt++;
        total_cnt++;
        if (utype_count !== exp_count)
            $display("[TB] FAIL throughput_count got %0d required %0d", utype_count, exp_count);
        else
            pass_cnt++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h222220B7; pc_in = 32'h700;
        tick;
        instr = 32'h33333117; pc_in = 32'h704;
        tick;
        flush = 1'b1; instr = 32'h444441B7; pc_in = 32'h708;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL flush_empty got ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
        else
            pass_cnt++;
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h55555237; pc_in = 32'h70C;
        tick;
        in_valid = 1'b0;
        tick;
        total_cnt++;
        if ({out_valid, exp_q.size() == 0, utype_count == exp_count} !== 3'b011)
            $display("[TB] FAIL flush_after got ov=%b pending=%0d cnt=%0d required ov=0 pending=0 cnt=%0d",
                     out_valid, exp_q.size(), utype_count, exp_count);
        else
            pass_cnt++;
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h666662B7; pc_in = 32'h710;
        tick;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        tick;
        flush = 1'b0;
        total_cnt++;
        if ({out_valid, utype_count} !== {1'b0, exp_count})
            $display("[TB] FAIL flush_count got ov=%b cnt=%0d required ov=0 cnt=%0d", out_valid, utype_count, exp_count);
        else
            pass_cnt++;
    endtask

    task automatic test_wrap;
        in_valid = 1'b0; out_ready = 1'b1;
        force dut.utype_count_q = 32'hFFFFFFFF;
        exp_count = 32'hFFFFFFFF;
        tick;
        release dut.utype_count_q;
        tick;
        total_cnt++;
        if (utype_count !== 32'hFFFFFFFF)
            $display("[TB] FAIL wrap_preload got %h required ffffffff", utype_count);
        else
            pass_cnt++;
        in_valid = 1'b1; instr = 32'h777773B7; pc_in = 32'h800;
        tick;
        in_valid = 1'b0;
        tick;
        total_cnt++;
        if (utype_count !== 32'h0)
            $display("[TB] FAIL wrap_count got %h required 00000000", utype_count);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h888880B7; pc_in = 32'h900;
        tick;
        instr = 32'h99999117; pc_in = 32'h904;
        tick;
        total_cnt++;
        if ({in_ready, out_valid, utype_count == 32'h0} !== 3'b011)
            $display("[TB] FAIL reset_mid_pre got ir=%b ov=%b cnt=%h required ir=0 ov=1 cnt=0", in_ready, out_valid, utype_count);
        else
            pass_cnt++;
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1; instr = 32'hABCDE1B7; pc_in = 32'h908;
        tick;
        total_cnt++;
        if ({out_valid, in_ready, pc, imm_u, aluSelect, rd, reg_write, is_utype, utype_count} !==
            {1'b0, 1'b1, 32'h0, 32'h0, 6'h0, 5'h0, 1'b0, 1'b0, 32'h0})
            $display("[TB] FAIL reset_mid got ov=%b ir=%b pc=%h imm=%h sel=%b rd=%0d rw=%b ut=%b cnt=%h required ov=0 ir=1 rest zero",
                     out_valid, in_ready, pc, imm_u, aluSelect, rd, reg_write, is_utype, utype_count);
        else
            pass_cnt++;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick;
        total_cnt++;
        if ({out_valid, utype_count} !== {1'b0, 32'h0})
            $display("[TB] FAIL reset_mid_after got ov=%b cnt=%h required ov=0 cnt=0", out_valid, utype_count);
        else
            pass_cnt++;
    endtask

    // Scenario sequence.
    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; pc_in = 32'h0;
        test_reset;
        test_lui;
        test_auipc;
        test_addi;
        test_back_to_back;
        test_throughput;
        test_flush;
        test_wrap;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
